ef_gpio8_irq_ctrl: RTL and testbench



---
 rtl/ef_gpio8_irq_ctrl.sv | 62 ++++++
 tb/tb_ef_gpio8_irq_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ef_gpio8_irq_ctrl.sv
// ef_gpio8_irq_ctrl: sticky GPIO event status, software mask and held-off interrupt line
//   clk, rst        : clock, synchronous active-high reset
//   pin_hi/lo/pe/ne : per-pin level and edge indications from the synchronizer stage
//   im_wr/im_wdata  : mask register write
//   icr_wr/icr_wdata: write-1-to-clear of raw status
//   ris, mis        : raw sticky status and masked status (ris & im)
//   irq             : registered interrupt request
module ef_gpio8_irq_ctrl #(
    parameter int unsigned HOLDOFF = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pin_hi,
    input  logic [7:0]  pin_lo,
    input  logic [7:0]  pin_pe,
    input  logic [7:0]  pin_ne,
    input  logic        im_wr,
    input  logic [31:0] im_wdata,
    input  logic        icr_wr,
    input  logic [31:0] icr_wdata,
    output logic [31:0] ris,
    output logic [31:0] mis,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;
    localparam logic [7:0] HOLD_LOAD = (HOLDOFF == 0) ? 8'd0 : 8'(HOLDOFF - 1);
    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [31:0] im;
    assign mis = ris & im;
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE:   state_next = |mis ? ASSERT : IDLE;
            ASSERT: if (mis == 32'h0) begin
                state_next = (HOLDOFF == 0) ? IDLE : HOLD;
                cnt_next   = HOLD_LOAD;
            end
            HOLD: begin
                state_next = (cnt == 8'd0) ? IDLE : HOLD;
                cnt_next   = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            ris   <= 32'h0;
            im    <= 32'h0;
            irq   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ris   <= (ris & ~(icr_wr ? icr_wdata : 32'h0)) | {pin_ne, pin_pe, pin_lo, pin_hi};
            im    <= im_wr ? im_wdata : im;
            irq   <= (state_next == ASSERT);
        end
    end
endmodule

// File: tb/tb_ef_gpio8_irq_ctrl.sv
// tb_ef_gpio8_irq_ctrl: directed checks of status capture, masking, hold-off and reset
module tb_ef_gpio8_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pin_hi = '0, pin_lo = '0, pin_pe = '0, pin_ne = '0;
    logic        im_wr = 1'b0, icr_wr = 1'b0;
    logic [31:0] im_wdata = '0, icr_wdata = '0;
    logic [31:0] ris, mis;
    logic        irq;
    int          errors = 0, checks = 0;

    ef_gpio8_irq_ctrl #(.HOLDOFF(4)) dut (
        .clk(clk), .rst(rst),
        .pin_hi(pin_hi), .pin_lo(pin_lo), .pin_pe(pin_pe), .pin_ne(pin_ne),
        .im_wr(im_wr), .im_wdata(im_wdata), .icr_wr(icr_wr), .icr_wdata(icr_wdata),
        .ris(ris), .mis(mis), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pin_pe = 8'hff;
        pin_hi = 8'hff;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ris", ris, 32'h0);
            check("rst_mis", mis, 32'h0);
            check("rst_irq", {31'h0, irq}, 32'h0);
        end
        pin_pe = '0;
        pin_hi = '0;
        rst = 1'b0;
        tick();
        check("post_rst_ris", ris, 32'h0);

        im_wr = 1'b1; im_wdata = 32'h0001_0000;
        tick();
        im_wr = 1'b0;
        check("im_only_mis", mis, 32'h0);
        pin_pe = 8'h01;
        tick();
        pin_pe = 8'h00;
        check("edge_ris", ris, 32'h0001_0000);
        check("edge_irq_n1", {31'h0, irq}, 32'h0);
        tick();
        check("edge_irq_n2", {31'h0, irq}, 32'h1);
        icr_wr = 1'b1; icr_wdata = 32'h0001_0000;
        tick();
        icr_wr = 1'b0;
        check("clr_ris", ris, 32'h0);
        check("clr_irq_hold", {31'h0, irq}, 32'h1);
        tick();
        check("clr_irq_drop", {31'h0, irq}, 32'h0);
        repeat (5) tick();

        pin_ne = 8'h08;
        tick();
        check("ne_ris", ris, 32'h0800_0000);
        icr_wr = 1'b1; icr_wdata = 32'h0800_0000;
        tick();
        pin_ne = 8'h00;
        check("set_wins", ris, 32'h0800_0000);
        tick();
        icr_wr = 1'b0;
        check("set_clr_later", ris, 32'h0);
        check("set_clr_irq", {31'h0, irq}, 32'h0);

        im_wr = 1'b1; im_wdata = 32'h0000_0080; pin_hi = 8'h80;
        tick();
        im_wr = 1'b0;
        check("lvl_ris", ris, 32'h0000_0080);
        tick();
        check("lvl_irq", {31'h0, irq}, 32'h1);
        icr_wr = 1'b1; icr_wdata = 32'h0000_0080;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lvl_reset_ris", ris, 32'h0000_0080);
            check("lvl_keep_irq", {31'h0, irq}, 32'h1);
        end
        pin_hi = 8'h00;
        tick();
        icr_wr = 1'b0;
        check("lvl_gone_ris", ris, 32'h0);
        tick();
        check("lvl_gone_irq", {31'h0, irq}, 32'h0);
        repeat (5) tick();

        im_wr = 1'b1; im_wdata = 32'h0005_0000; pin_pe = 8'h01;
        tick();
        im_wr = 1'b0; pin_pe = 8'h00;
        tick();
        check("ho_irq_up", {31'h0, irq}, 32'h1);
        icr_wr = 1'b1; icr_wdata = 32'h0001_0000;
        tick();
        icr_wr = 1'b0;
        pin_pe = 8'h04;
        tick();
        pin_pe = 8'h00;
        check("ho_first_low", {31'h0, irq}, 32'h0);
        check("ho_ris_set", ris, 32'h0004_0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ho_irq_low", {31'h0, irq}, 32'h0);
            check("ho_ris_kept", ris, 32'h0004_0000);
        end
        tick();
        check("ho_irq_back", {31'h0, irq}, 32'h1);

        im_wr = 1'b1; im_wdata = 32'h0;
        tick();
        im_wr = 1'b0;
        check("mask_mis", mis, 32'h0);
        check("mask_irq_still", {31'h0, irq}, 32'h1);
        tick();
        check("mask_irq_drop", {31'h0, irq}, 32'h0);
        check("mask_ris", ris, 32'h0004_0000);
        im_wr = 1'b1; im_wdata = 32'h0004_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            im_wr = 1'b0;
            check("unmask_hold_irq", {31'h0, irq}, 32'h0);
        end
        tick();
        check("unmask_irq", {31'h0, irq}, 32'h1);
        check("unmask_mis", mis, 32'h0004_0000);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_irq", {31'h0, irq}, 32'h0);
        check("midrst_ris", ris, 32'h0);
        check("midrst_mis", mis, 32'h0);
        tick();
        check("midrst_after_irq", {31'h0, irq}, 32'h0);

        pin_pe = 8'h01;
        tick();
        pin_pe = 8'h00;
        tick();
        check("idle_masked_irq", {31'h0, irq}, 32'h0);
        check("idle_masked_ris", ris, 32'h0001_0000);
        im_wr = 1'b1; im_wdata = 32'h0001_0000;
        tick();
        im_wr = 1'b0;
        check("unmask_idle_n1", {31'h0, irq}, 32'h0);
        tick();
        check("unmask_idle_n2", {31'h0, irq}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
